exec_sequencer: RTL and testbench

- Multi-cycle control FSM for the single-issue core. Produces the 3-bit state fed to the execute stage and divider, and owns the PC.
- Sequences fetch, decode, execute, memory and writeback, and holds EXECUTE while the divider requests a stall.
- Handles instruction and data memory request/ack handshakes with timeouts.
- Raises sticky traps, and counts retired instructions.

---
 rtl/exec_sequencer_pkg.sv | 28 ++
 rtl/mem_wait_timer.sv | 40 ++++
 rtl/exec_sequencer.sv | 167 ++++++++++++++++
 tb/tb_exec_sequencer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_sequencer_pkg.sv
// exec_sequencer shared definitions
// FSM state and trap cause encodings
package exec_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_MEMORY    = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_TRAP      = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    TRAP_ILLEGAL  = 2'd0,
    TRAP_IMEM_TO  = 2'd1,
    TRAP_DMEM_TO  = 2'd2,
    TRAP_MISALIGN = 2'd3
  } cause_e;

  function automatic logic is_misaligned(
    input logic       taken,
    input logic [1:0] lsb
  );
    return taken & (lsb != 2'b00);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: ack wait counter
// expired_o flags the last allowed wait cycle
module mem_wait_timer #(
  parameter int LIMIT = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int W = $clog2(LIMIT);
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // clear wins over count
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // counter register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == LAST);

endmodule

// File: rtl/exec_sequencer.sv
// exec_sequencer: multi-cycle core control FSM
// owns PC, retire count and sticky trap state
module exec_sequencer
  import exec_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          MEM_TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        imem_ack_i,
  input  logic        dmem_ack_i,
  input  logic        illegal_i,
  input  logic        ex_stall_i,
  input  logic        is_load_i,
  input  logic        is_store_i,
  input  logic        no_wb_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_addr_i,
  output logic [2:0]  state_o,
  output logic [31:0] pc_o,
  output logic        imem_req_o,
  output logic        ir_we_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic        rf_we_o,
  output logic        retire_o,
  output logic [31:0] instret_o,
  output logic        trap_o,
  output logic [1:0]  trap_cause_o
);

  state_e      state_q, state_d;
  cause_e      cause_q, cause_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instret_q, instret_d;
  logic        trap_q, trap_d;

  logic waiting;
  logic ack_sel;
  logic expired;
  logic misaligned;

  assign waiting    = (state_q == ST_FETCH) || (state_q == ST_MEMORY);
  assign ack_sel    = (state_q == ST_FETCH) ? imem_ack_i : dmem_ack_i;
  assign misaligned = is_misaligned(branch_taken_i, branch_addr_i[1:0]);

  mem_wait_timer #(
    .LIMIT(MEM_TIMEOUT)
  ) u_timer (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (~waiting | ack_sel | expired),
    .en_i     (waiting & ~ack_sel),
    .expired_o(expired)
  );

  // next-state, pc, retire count and trap capture
  always_comb begin
    state_d   = state_q;
    cause_d   = cause_q;
    pc_d      = pc_q;
    instret_d = instret_q;
    trap_d    = trap_q;
    unique case (state_q)
      ST_FETCH: begin
        if (imem_ack_i) begin
          state_d = ST_DECODE;
        end else if (expired) begin
          state_d = ST_TRAP;
          cause_d = TRAP_IMEM_TO;
          trap_d  = 1'b1;
        end
      end
      ST_DECODE: begin
        if (illegal_i) begin
          state_d = ST_TRAP;
          cause_d = TRAP_ILLEGAL;
          trap_d  = 1'b1;
        end else begin
          state_d = ST_EXECUTE;
        end
      end
      ST_EXECUTE: begin
        if (!ex_stall_i) begin
          state_d = (is_load_i | is_store_i) ? ST_MEMORY : ST_WRITEBACK;
        end
      end
      ST_MEMORY: begin
        if (dmem_ack_i) begin
          state_d = ST_WRITEBACK;
        end else if (expired) begin
          state_d = ST_TRAP;
          cause_d = TRAP_DMEM_TO;
          trap_d  = 1'b1;
        end
      end
      ST_WRITEBACK: begin
        if (misaligned) begin
          state_d = ST_TRAP;
          cause_d = TRAP_MISALIGN;
          trap_d  = 1'b1;
        end else begin
          pc_d      = branch_taken_i ? branch_addr_i : pc_q + 32'd4;
          instret_d = instret_q + 32'd1;
          state_d   = ST_FETCH;
        end
      end
      ST_TRAP: begin
        state_d = ST_TRAP;
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  // architectural registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_FETCH;
      cause_q   <= TRAP_ILLEGAL;
      pc_q      <= RESET_PC;
      instret_q <= '0;
      trap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cause_q   <= cause_d;
      pc_q      <= pc_d;
      instret_q <= instret_d;
      trap_q    <= trap_d;
    end
  end

  // handshake strobes decoded from state
  always_comb begin
    imem_req_o = 1'b0;
    ir_we_o    = 1'b0;
    dmem_req_o = 1'b0;
    dmem_we_o  = 1'b0;
    rf_we_o    = 1'b0;
    retire_o   = 1'b0;
    unique case (state_q)
      ST_FETCH: begin
        imem_req_o = 1'b1;
        ir_we_o    = imem_ack_i;
      end
      ST_MEMORY: begin
        dmem_req_o = 1'b1;
        dmem_we_o  = is_store_i;
      end
      ST_WRITEBACK: begin
        rf_we_o  = ~no_wb_i & ~misaligned;
        retire_o = ~misaligned;
      end
      default: begin
      end
    endcase
  end

  assign state_o      = state_q;
  assign pc_o         = pc_q;
  assign instret_o    = instret_q;
  assign trap_o       = trap_q;
  assign trap_cause_o = cause_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// tb_exec_sequencer: directed checks of the control FSM
// inputs change and outputs sample 1ns after posedge
module tb_exec_sequencer;

  localparam int TO = 16;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        imem_ack_i;
  logic        dmem_ack_i;
  logic        illegal_i;
  logic        ex_stall_i;
  logic        is_load_i;
  logic        is_store_i;
  logic        no_wb_i;
  logic        branch_taken_i;
  logic [31:0] branch_addr_i;
  logic [2:0]  state_o;
  logic [31:0] pc_o;
  logic        imem_req_o;
  logic        ir_we_o;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic        rf_we_o;
  logic        retire_o;
  logic [31:0] instret_o;
  logic        trap_o;
  logic [1:0]  trap_cause_o;

  int n_checks = 0;
  int n_fail   = 0;

  exec_sequencer #(
    .RESET_PC   (32'h0000_0000),
    .MEM_TIMEOUT(TO)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .imem_ack_i    (imem_ack_i),
    .dmem_ack_i    (dmem_ack_i),
    .illegal_i     (illegal_i),
    .ex_stall_i    (ex_stall_i),
    .is_load_i     (is_load_i),
    .is_store_i    (is_store_i),
    .no_wb_i       (no_wb_i),
    .branch_taken_i(branch_taken_i),
    .branch_addr_i (branch_addr_i),
    .state_o       (state_o),
    .pc_o          (pc_o),
    .imem_req_o    (imem_req_o),
    .ir_we_o       (ir_we_o),
    .dmem_req_o    (dmem_req_o),
    .dmem_we_o     (dmem_we_o),
    .rf_we_o       (rf_we_o),
    .retire_o      (retire_o),
    .instret_o     (instret_o),
    .trap_o        (trap_o),
    .trap_cause_o  (trap_cause_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clr_in();
    imem_ack_i     = 1'b0;
    dmem_ack_i     = 1'b0;
    illegal_i      = 1'b0;
    ex_stall_i     = 1'b0;
    is_load_i      = 1'b0;
    is_store_i     = 1'b0;
    no_wb_i        = 1'b0;
    branch_taken_i = 1'b0;
    branch_addr_i  = 32'h0;
  endtask

  task automatic do_reset();
    clr_in();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
  endtask

  // fetch with immediate ack, then decode (legal)
  task automatic to_execute();
    imem_ack_i = 1'b1;
    tick();
    imem_ack_i = 1'b0;
    tick();
  endtask

  int bad;

  initial begin
    do_reset();
    #1;
    check("rst_state", state_o, 0);
    check("rst_pc", pc_o, 0);
    check("rst_instret", instret_o, 0);
    check("rst_trap", trap_o, 0);
    check("rst_cause", trap_cause_o, 0);
    check("rst_strobes", {dmem_req_o, rf_we_o, retire_o, ir_we_o}, 0);

    // ALU op, immediate acks
    imem_ack_i = 1'b1;
    #1;
    check("alu_irwe", ir_we_o, 1);
    tick();
    imem_ack_i = 1'b0;
    check("alu_dec", state_o, 1);
    tick();
    check("alu_ex", state_o, 2);
    tick();
    check("alu_wb", state_o, 4);
    check("alu_wb_rf_ret", {rf_we_o, retire_o}, 2'b11);
    tick();
    check("alu_fetch", state_o, 0);
    check("alu_pc", pc_o, 4);
    check("alu_instret", instret_o, 1);
    check("alu_ret_low", retire_o, 0);

    // load, dmem ack on 4th MEMORY cycle
    to_execute();
    is_load_i = 1'b1;
    tick();
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      dmem_ack_i = (i == 3);
      #1;
      if (state_o != 3 || !dmem_req_o || dmem_we_o) bad++;
      tick();
    end
    dmem_ack_i = 1'b0;
    check("ld_mem_hold", bad, 0);
    check("ld_wb", state_o, 4);
    check("ld_rfwe", rf_we_o, 1);
    tick();
    is_load_i = 1'b0;
    check("ld_pc", pc_o, 8);
    check("ld_instret", instret_o, 2);

    // divide stalls 33 cycles
    to_execute();
    bad = 0;
    for (int i = 0; i < 34; i++) begin
      ex_stall_i = (i < 33);
      if (state_o != 2 || trap_o) bad++;
      tick();
    end
    ex_stall_i = 1'b0;
    check("div_hold", bad, 0);
    check("div_wb", state_o, 4);
    tick();
    check("div_instret", instret_o, 3);

    // taken branch to 0x100, no rd write
    to_execute();
    tick();
    branch_taken_i = 1'b1;
    branch_addr_i  = 32'h100;
    no_wb_i        = 1'b1;
    #1;
    check("br_rfwe", rf_we_o, 0);
    check("br_retire", retire_o, 1);
    tick();
    clr_in();
    check("br_pc", pc_o, 32'h100);
    check("br_instret", instret_o, 4);

    // misaligned target traps
    to_execute();
    tick();
    branch_taken_i = 1'b1;
    branch_addr_i  = 32'h102;
    #1;
    check("mis_retire", {rf_we_o, retire_o}, 0);
    tick();
    clr_in();
    check("mis_state", state_o, 5);
    check("mis_trap", {trap_o, trap_cause_o}, {1'b1, 2'd3});
    check("mis_pc", pc_o, 32'h100);
    check("mis_instret", instret_o, 4);

    // imem timeout
    do_reset();
    bad = 0;
    for (int i = 0; i < TO; i++) begin
      if (state_o != 0 || !imem_req_o) bad++;
      tick();
    end
    check("ito_hold", bad, 0);
    check("ito_state", state_o, 5);
    check("ito_cause", {trap_o, trap_cause_o}, {1'b1, 2'd1});

    // ack on final cycle wins
    do_reset();
    for (int i = 0; i < TO; i++) begin
      imem_ack_i = (i == TO - 1);
      tick();
    end
    imem_ack_i = 1'b0;
    check("ilast_state", state_o, 1);
    check("ilast_trap", trap_o, 0);

    // illegal in decode, sticky
    illegal_i = 1'b1;
    tick();
    illegal_i = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      imem_ack_i = i[0];
      #1;
      if (state_o != 5 || !trap_o || trap_cause_o != 0) bad++;
      if (imem_req_o || ir_we_o || dmem_req_o || retire_o) bad++;
      if (pc_o != 0) bad++;
      tick();
    end
    imem_ack_i = 1'b0;
    check("ill_sticky", bad, 0);

    // dmem timeout on a store
    do_reset();
    to_execute();
    is_store_i = 1'b1;
    tick();
    check("st_we", {dmem_req_o, dmem_we_o}, 2'b11);
    for (int i = 0; i < TO; i++) tick();
    check("dto_state", state_o, 5);
    check("dto_cause", trap_cause_o, 2);

    // reset mid-MEMORY
    do_reset();
    to_execute();
    is_store_i = 1'b1;
    tick();
    tick();
    check("rm_pre", state_o, 3);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("rm_state", state_o, 0);
    check("rm_pc", pc_o, 0);
    check("rm_dreq", dmem_req_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
